// File: rtl/fadd_arb.sv
// fadd_arb: round-robin arbiter sharing one pipelined fadd among NREQ requesters
//   clk, rst               clock, synchronous active-high reset
//   req_valid/req_ready    per-requester handshake, one-hot combinational grant
//   req_x1/req_x2/req_sub  per-requester operands (32 bits each) and subtract flag
//   flush                  drops every in-flight operation
//   fadd_x1/fadd_x2        registered operands to the external adder
//   fadd_y                 adder result, LATENCY cycles after the operands
//   resp_valid/resp_y      one-hot registered response pulse and result
//   busy                   any accepted operation still awaiting its response
module fadd_arb #(
    parameter int NREQ    = 4,
    parameter int LATENCY = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*32-1:0] req_x1,
    input  logic [NREQ*32-1:0] req_x2,
    input  logic [NREQ-1:0]    req_sub,
    input  logic               flush,
    output logic [31:0]        fadd_x1,
    output logic [31:0]        fadd_x2,
    input  logic [31:0]        fadd_y,
    output logic [NREQ-1:0]    resp_valid,
    output logic [31:0]        resp_y,
    output logic               busy
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IW-1:0]              ptr_q, ptr_d, gnt_idx;
    logic [IW:0]                idx;
    logic                       found, hs, fire;
    logic [31:0]                fadd_x1_q, fadd_x1_d, fadd_x2_q, fadd_x2_d;
    logic [LATENCY:0]           tag_v_q, tag_v_d;
    logic [LATENCY:0][IW-1:0]   tag_i_q, tag_i_d;
    logic [NREQ-1:0]            resp_valid_q, resp_valid_d;
    logic [31:0]                resp_y_q, resp_y_d;

    // Scan requesters starting at the pointer, wrapping modulo NREQ; first valid wins.
    always_comb begin
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, ptr_q} + (IW+1)'(k);
            if (idx >= (IW+1)'(NREQ)) idx = idx - (IW+1)'(NREQ);
            if (!found && req_valid[idx[IW-1:0]]) begin
                found   = 1'b1;
                gnt_idx = idx[IW-1:0];
            end
        end
    end

    always_comb begin
        req_ready = (rst || flush || !found) ? '0 : NREQ'(1) << gnt_idx;
        hs        = |req_ready;
        ptr_d     = hs ? ((gnt_idx == IW'(NREQ-1)) ? '0 : gnt_idx + 1'b1) : ptr_q;
        fadd_x1_d = hs ? req_x1[32*gnt_idx +: 32] : fadd_x1_q;
        // Subtraction is addition with the sign of x2 flipped.
        fadd_x2_d = hs ? (req_x2[32*gnt_idx +: 32] ^ {req_sub[gnt_idx], 31'b0}) : fadd_x2_q;
        // Tag stage k lines up with the adder output LATENCY cycles after issue.
        tag_v_d   = flush ? '0 : {tag_v_q[LATENCY-1:0], hs};
        tag_i_d   = {tag_i_q[LATENCY-1:0], gnt_idx};
        // An op reaching the last stage during flush was accepted before it, so drop it too.
        fire         = tag_v_q[LATENCY] && !flush;
        resp_valid_d = fire ? NREQ'(1) << tag_i_q[LATENCY] : '0;
        resp_y_d     = fire ? fadd_y : resp_y_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q        <= '0;
            fadd_x1_q    <= '0;
            fadd_x2_q    <= '0;
            tag_v_q      <= '0;
            tag_i_q      <= '0;
            resp_valid_q <= '0;
            resp_y_q     <= '0;
        end else begin
            ptr_q        <= ptr_d;
            fadd_x1_q    <= fadd_x1_d;
            fadd_x2_q    <= fadd_x2_d;
            tag_v_q      <= tag_v_d;
            tag_i_q      <= tag_i_d;
            resp_valid_q <= resp_valid_d;
            resp_y_q     <= resp_y_d;
        end
    end

    assign fadd_x1    = fadd_x1_q;
    assign fadd_x2    = fadd_x2_q;
    assign resp_valid = resp_valid_q;
    assign resp_y     = resp_y_q;
    assign busy       = |tag_v_q || |resp_valid_q;
endmodule

// File: tb/tb_fadd_arb.sv
// tb_fadd_arb: directed self-checking bench for fadd_arb with a behavioural 2-stage adder
module tb_fadd_arb;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   req_valid = '0;
    logic [3:0]   req_ready;
    logic [127:0] req_x1 = '0;
    logic [127:0] req_x2 = '0;
    logic [3:0]   req_sub = '0;
    logic         flush = 1'b0;
    logic [31:0]  fadd_x1, fadd_x2, fadd_y;
    logic [3:0]   resp_valid;
    logic [31:0]  resp_y;
    logic         busy;
    logic [31:0]  p0 = '0, p1 = '0;
    int           checks = 0;
    int           errors = 0;

    fadd_arb #(.NREQ(4), .LATENCY(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_x1(req_x1), .req_x2(req_x2), .req_sub(req_sub), .flush(flush),
        .fadd_x1(fadd_x1), .fadd_x2(fadd_x2), .fadd_y(fadd_y),
        .resp_valid(resp_valid), .resp_y(resp_y), .busy(busy)
    );

    always #5 clk = ~clk;

    // Stand-in adder: exact for the directed float vectors, XOR otherwise so results stay traceable.
    function automatic logic [31:0] fake_add(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        if (a == 32'h40400000 && b == 32'hBF800000) return 32'h40000000;
        return a ^ b;
    endfunction

    always @(posedge clk) begin
        p0 <= fake_add(fadd_x1, fadd_x2);
        p1 <= p0;
    end
    assign fadd_y = p1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 4'b1111;
        tick();
        checks++;
        if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b exp 0000", req_ready); end
        req_valid = '0;
        tick();
        checks++;
        if ({resp_valid, resp_y, fadd_x1, fadd_x2, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: rv=%b y=%h x1=%h x2=%h busy=%b exp all 0", resp_valid, resp_y, fadd_x1, fadd_x2, busy);
        end
        rst = 1'b0;
        req_valid = 4'b1111;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin errors++; $display("FAIL reset_first_grant: got %b exp 0001", req_ready); end
        req_valid = '0;
        tick();
    endtask

    task automatic test_single();
        req_valid = 4'b0100;
        req_x1[64 +: 32] = 32'h3F800000;
        req_x2[64 +: 32] = 32'h40000000;
        req_sub = '0;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b exp 0100", req_ready); end
        tick();
        req_valid = '0;
        checks++;
        if (fadd_x1 !== 32'h3F800000 || fadd_x2 !== 32'h40000000) begin
            errors++; $display("FAIL single_operands: got %h %h exp 3f800000 40000000", fadd_x1, fadd_x2);
        end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b exp 1", busy); end
        tick();
        tick();
        checks++;
        if (resp_valid !== 4'b0000) begin errors++; $display("FAIL single_early: got %b exp 0000", resp_valid); end
        tick();
        checks++;
        if (resp_valid !== 4'b0100 || resp_y !== 32'h40400000) begin
            errors++; $display("FAIL single_resp: got %b %h exp 0100 40400000", resp_valid, resp_y);
        end
        tick();
        checks++;
        if (resp_valid !== 4'b0000 || busy !== 1'b0) begin
            errors++; $display("FAIL single_idle: got rv=%b busy=%b exp 0000 0", resp_valid, busy);
        end
    endtask

    task automatic test_sub();
        req_valid = 4'b0001;
        req_x1[0 +: 32] = 32'h40400000;
        req_x2[0 +: 32] = 32'h3F800000;
        req_sub = 4'b0001;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin errors++; $display("FAIL sub_grant_wrap: got %b exp 0001", req_ready); end
        tick();
        req_valid = '0;
        req_sub = '0;
        checks++;
        if (fadd_x2 !== 32'hBF800000) begin errors++; $display("FAIL sub_x2: got %h exp bf800000", fadd_x2); end
        tick();
        tick();
        tick();
        checks++;
        if (resp_valid !== 4'b0001 || resp_y !== 32'h40000000) begin
            errors++; $display("FAIL sub_resp: got %b %h exp 0001 40000000", resp_valid, resp_y);
        end
        tick();
    endtask

    task automatic test_fair();
        logic [31:0] exp_y [8];
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (c < 8) begin
                req_valid = 4'b1111;
                for (int i = 0; i < 4; i++) begin
                    req_x1[32*i +: 32] = {8'hA0 + 8'(c), 24'(i)};
                    req_x2[32*i +: 32] = 32'h00010000 * (c + 1);
                end
                exp_y[c] = {8'hA0 + 8'(c), 24'(c % 4)} ^ (32'h00010000 * (c + 1));
                #1;
                checks++;
                if (req_ready !== 4'(1 << (c % 4))) begin
                    errors++; $display("FAIL fair_grant[%0d]: got %b exp %b", c, req_ready, 4'(1 << (c % 4)));
                end
            end else begin
                req_valid = '0;
            end
            if (c >= 4) begin
                checks++;
                if (resp_valid !== 4'(1 << ((c - 4) % 4)) || resp_y !== exp_y[c-4]) begin
                    errors++;
                    $display("FAIL fair_resp[%0d]: got %b %h exp %b %h", c - 4, resp_valid, resp_y, 4'(1 << ((c - 4) % 4)), exp_y[c-4]);
                end
            end
            tick();
        end
        checks++;
        if (resp_valid !== 4'b0000 || busy !== 1'b0) begin
            errors++; $display("FAIL fair_drain: got rv=%b busy=%b exp 0000 0", resp_valid, busy);
        end
    endtask

    task automatic test_flush();
        req_valid = 4'b0010;
        tick();
        req_valid = 4'b0100;
        tick();
        req_valid = 4'b0001;
        flush = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin errors++; $display("FAIL flush_ready: got %b exp 0000", req_ready); end
        tick();
        flush = 1'b0;
        req_valid = '0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b exp 0", busy); end
        for (int c = 3; c <= 6; c++) begin
            checks++;
            if (resp_valid !== 4'b0000) begin errors++; $display("FAIL flush_resp[t+%0d]: got %b exp 0000", c, resp_valid); end
            tick();
        end
        req_valid = 4'b1111;
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin errors++; $display("FAIL flush_ptr_hold: got %b exp 1000", req_ready); end
        req_valid = '0;
        tick();
    endtask

    task automatic test_rst_mid();
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({resp_valid, resp_y, fadd_x1, fadd_x2, busy} !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs: rv=%b y=%h x1=%h x2=%h busy=%b exp all 0", resp_valid, resp_y, fadd_x1, fadd_x2, busy);
        end
        req_valid = 4'b1111;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin errors++; $display("FAIL rstmid_grant: got %b exp 0001", req_ready); end
        req_valid = '0;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (resp_valid !== 4'b0000) begin errors++; $display("FAIL rstmid_resp[%0d]: got %b exp 0000", c, resp_valid); end
        end
    endtask

    task automatic test_back_to_back();
        req_valid = 4'b1000;
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin errors++; $display("FAIL sparse_grant3: got %b exp 1000", req_ready); end
        tick();
        req_valid = 4'b0010;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin errors++; $display("FAIL sparse_grant1: got %b exp 0010", req_ready); end
        tick();
        req_valid = 4'b1111;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin errors++; $display("FAIL sparse_ptr: got %b exp 0100", req_ready); end
        req_valid = '0;
        tick();
        tick();
        checks++;
        if (resp_valid !== 4'b1000) begin errors++; $display("FAIL sparse_resp3: got %b exp 1000", resp_valid); end
        tick();
        checks++;
        if (resp_valid !== 4'b0010) begin errors++; $display("FAIL sparse_resp1: got %b exp 0010", resp_valid); end
        tick();
        checks++;
        if (resp_valid !== 4'b0000 || busy !== 1'b0) begin
            errors++; $display("FAIL sparse_drain: got rv=%b busy=%b exp 0000 0", resp_valid, busy);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_sub();
        test_fair();
        test_flush();
        test_rst_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
